// File: rtl/wr_arbiter.sv
// Round-robin arbiter sharing one DDR write channel among up to four wr_cell writers.
// Define WR_ARB_TIMEOUT_EN to enable the REQ/DATA watchdog (TIMEOUT_CYCLES).
module wr_arbiter #(
  parameter int unsigned CH_NUM         = 4,
  parameter int unsigned ADDR_WIDTH     = 27,
  parameter int unsigned DQ_WIDTH       = 32,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                           i_ddr_clk,
  input  logic                           i_ddr_rst,
  input  logic [CH_NUM-1:0]              i_s_wreq,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]   i_s_waddr,
  input  logic [CH_NUM*LEN_WIDTH-1:0]    i_s_wr_len,
  input  logic [CH_NUM*8*DQ_WIDTH-1:0]   i_s_wdata,
  output logic [CH_NUM-1:0]              o_s_wdata_req,
  output logic [CH_NUM-1:0]              o_s_wdone,
  output logic                           o_ddr_wreq,
  output logic [ADDR_WIDTH-1:0]          o_ddr_waddr,
  output logic [LEN_WIDTH-1:0]           o_ddr_wr_len,
  output logic [8*DQ_WIDTH-1:0]          o_ddr_wdata,
  input  logic                           i_ddr_wdata_req,
  input  logic                           i_ddr_wdone,
  output logic [CH_NUM-1:0]              o_arb_grant,
  output logic                           o_arb_busy,
  output logic                           o_arb_err
);
  localparam int unsigned DW = 8 * DQ_WIDTH;
  localparam int unsigned BW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_t;

  state_t                  r_state;
  logic [1:0]              r_ptr;
  logic [CH_NUM-1:0]       r_grant;
  logic                    r_wreq;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [LEN_WIDTH-1:0]    r_wr_len;
  logic                    r_busy;
  logic                    r_err;
  logic [BW-1:0]           r_beat;

  logic                    w_found;
  logic [1:0]              w_win;
  logic [1:0]              w_idx;
  logic [DW-1:0]           w_wdata;
  logic [BW-1:0]           w_beat_nxt;
  logic                    w_beat_over;

  // Search starts one past the last winner, so every waiting channel is served within CH_NUM grants
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 1; k <= int'(CH_NUM); k++) begin
      w_idx = 2'((int'(r_ptr) + k) % int'(CH_NUM));
      if (!w_found && i_s_wreq[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (r_grant[i]) w_wdata = w_wdata | i_s_wdata[i*DW +: DW];
    end
  end

  assign w_beat_nxt  = (&r_beat) ? r_beat : r_beat + 1'b1;
  assign w_beat_over = w_beat_nxt > {1'b0, r_wr_len};

`ifdef WR_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_tmo;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge i_ddr_clk or posedge i_ddr_rst) begin
    if (i_ddr_rst) begin
      r_state  <= StIdle;
      r_ptr    <= 2'(CH_NUM - 1);
      r_grant  <= '0;
      r_wreq   <= 1'b0;
      r_waddr  <= '0;
      r_wr_len <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_beat   <= '0;
`ifdef WR_ARB_TIMEOUT_EN
      r_tmo    <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_ddr_wdata_req) r_err <= 1'b1;
          if (w_found) begin
            r_grant  <= CH_NUM'(1) << w_win;
            r_ptr    <= w_win;
            r_waddr  <= i_s_waddr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
            r_wr_len <= i_s_wr_len[w_win*LEN_WIDTH +: LEN_WIDTH];
            r_wreq   <= 1'b1;
            r_busy   <= 1'b1;
            r_beat   <= '0;
`ifdef WR_ARB_TIMEOUT_EN
            r_tmo    <= '0;
`endif
            r_state  <= StReq;
          end
        end
        StReq: begin
          if (i_ddr_wdone) r_err <= 1'b1;
          if (i_ddr_wdata_req) begin
            r_wreq  <= 1'b0;
            r_beat  <= BW'(1);
            if (r_wr_len == '0) r_err <= 1'b1;
            r_state <= StData;
          end
        end
        StData: begin
          if (i_ddr_wdata_req) begin
            r_beat <= w_beat_nxt;
            if (w_beat_over) r_err <= 1'b1;
          end
          if (i_ddr_wdone) r_state <= StDone;
        end
        StDone: begin
          if (i_ddr_wdata_req) r_err <= 1'b1;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
`ifdef WR_ARB_TIMEOUT_EN
      // Abort overrides any handshake seen on the same edge; r_ptr keeps the aborted channel
      if (r_state == StReq || r_state == StData) begin
        r_tmo <= r_tmo + 1'b1;
        if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          r_err   <= 1'b1;
          r_wreq  <= 1'b0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      end
`endif
    end
  end

  assign o_s_wdata_req = {CH_NUM{i_ddr_wdata_req}} & r_grant;
  assign o_s_wdone     = {CH_NUM{i_ddr_wdone && (r_state == StData)}} & r_grant;
  assign o_ddr_wreq    = r_wreq;
  assign o_ddr_waddr   = r_waddr;
  assign o_ddr_wr_len  = r_wr_len;
  assign o_ddr_wdata   = w_wdata;
  assign o_arb_grant   = r_grant;
  assign o_arb_busy    = r_busy;
  assign o_arb_err     = r_err;

endmodule

// File: tb/tb_wr_arbiter.sv
// Bench for wr_arbiter: plays the DDR controller and checks against a round-robin burst model.
module tb_wr_arbiter;
  localparam int CH = 4;
  localparam int AW = 27;
  localparam int DQ = 32;
  localparam int LW = 16;
  localparam int DW = 8 * DQ;
`ifdef WR_ARB_TIMEOUT_EN
  localparam int TMO      = 16;
  localparam int MaxLen   = 4;
  localparam int MaxGap   = 0;
  localparam int MaxWait  = 1;
  localparam int FirstLen = 4;
`else
  localparam int TMO      = 4096;
  localparam int MaxLen   = 12;
  localparam int MaxGap   = 2;
  localparam int MaxWait  = 3;
  localparam int FirstLen = 40;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     s_wreq;
  logic [CH*AW-1:0]  s_waddr;
  logic [CH*LW-1:0]  s_wr_len;
  logic [CH*DW-1:0]  s_wdata;
  logic [CH-1:0]     s_wdata_req;
  logic [CH-1:0]     s_wdone;
  logic              ddr_wreq;
  logic [AW-1:0]     ddr_waddr;
  logic [LW-1:0]     ddr_wr_len;
  logic [DW-1:0]     ddr_wdata;
  logic              ddr_wdata_req;
  logic              ddr_wdone;
  logic [CH-1:0]     arb_grant;
  logic              arb_busy;
  logic              arb_err;

  int   checks = 0;
  int   errors = 0;
  int   ptr;           // model: last granted channel
  logic exp_err;       // model: arb_err expected after the next edge

  wr_arbiter #(
    .CH_NUM(CH), .ADDR_WIDTH(AW), .DQ_WIDTH(DQ), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .i_ddr_clk(clk), .i_ddr_rst(rst),
    .i_s_wreq(s_wreq), .i_s_waddr(s_waddr), .i_s_wr_len(s_wr_len), .i_s_wdata(s_wdata),
    .o_s_wdata_req(s_wdata_req), .o_s_wdone(s_wdone),
    .o_ddr_wreq(ddr_wreq), .o_ddr_waddr(ddr_waddr), .o_ddr_wr_len(ddr_wr_len),
    .o_ddr_wdata(ddr_wdata), .i_ddr_wdata_req(ddr_wdata_req), .i_ddr_wdone(ddr_wdone),
    .o_arb_grant(arb_grant), .o_arb_busy(arb_busy), .o_arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_eq("arb_err", 256'(arb_err), 256'(exp_err));
    exp_err = 1'b0;
  endtask

  function automatic int rr_pick(input int p, input logic [CH-1:0] req);
    for (int k = 1; k <= CH; k++) begin
      if (req[(p + k) % CH]) return (p + k) % CH;
    end
    return 0;
  endfunction

  task automatic rand_data();
    for (int j = 0; j < CH * DW / 32; j++) s_wdata[j*32 +: 32] = $urandom;
  endtask

  task automatic rand_ctrl();
    for (int c = 0; c < CH; c++) begin
      s_waddr[c*AW +: AW]  = AW'($urandom);
      s_wr_len[c*LW +: LW] = LW'($urandom_range(MaxLen, 1));
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    s_wreq = '0;
    ddr_wdata_req = 1'b0;
    ddr_wdone = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ptr = CH - 1;
    exp_err = 1'b0;
  endtask

  // One full burst from IDLE back to IDLE; extra = beats beyond the latched length
  task automatic burst(input logic [CH-1:0] req, input int force_len, input int extra,
                       input int force_addr);
    int w, len, nb;
    logic [CH-1:0] oh;
    logic [AW-1:0] a;
    bit done;
    rand_ctrl();
    w = rr_pick(ptr, req);
    if (force_len > 0) s_wr_len[w*LW +: LW] = LW'(force_len);
    if (force_addr >= 0) s_waddr[w*AW +: AW] = AW'(force_addr);
    a   = s_waddr[w*AW +: AW];
    len = int'(s_wr_len[w*LW +: LW]);
    oh  = CH'(1) << w;
    s_wreq = req;
    step();
    ptr = w;
    check_eq("grant", 256'(arb_grant), 256'(oh));
    check_eq("wreq", 256'(ddr_wreq), 256'(1));
    check_eq("waddr", 256'(ddr_waddr), 256'(a));
    check_eq("wr_len", 256'(ddr_wr_len), 256'(len));
    check_eq("busy", 256'(arb_busy), 256'(1));
    s_wreq = CH'($urandom);
    rand_ctrl();
    repeat ($urandom_range(MaxWait, 0)) begin
      step();
      check_eq("wreq_hold", 256'(ddr_wreq), 256'(1));
    end
    nb = len + extra;
    done = 1'b0;
    for (int b = 1; b <= nb; b++) begin
      repeat ($urandom_range(MaxGap, 0)) step();
      rand_data();
      ddr_wdata_req = 1'b1;
      done = (b == nb) && (b > 1) && ($urandom_range(1, 0) == 1);
      ddr_wdone = done;
      #1;
      check_eq("s_wdata_req", 256'(s_wdata_req), 256'(oh));
      check_eq("ddr_wdata", 256'(ddr_wdata), 256'(s_wdata[w*DW +: DW]));
      check_eq("s_wdone_beat", 256'(s_wdone), done ? 256'(oh) : 256'(0));
      exp_err = (b > len);
      step();
      ddr_wdata_req = 1'b0;
      ddr_wdone = 1'b0;
      check_eq("wreq_drop", 256'(ddr_wreq), 256'(0));
    end
    if (!done) begin
      repeat ($urandom_range(MaxGap, 0)) step();
      ddr_wdone = 1'b1;
      #1;
      check_eq("s_wdone", 256'(s_wdone), 256'(oh));
      step();
      ddr_wdone = 1'b0;
    end
    #1;
    check_eq("done_grant", 256'(arb_grant), 256'(oh));
    check_eq("done_busy", 256'(arb_busy), 256'(1));
    check_eq("done_s_wdone", 256'(s_wdone), 256'(0));
    s_wreq = '0;
    step();
    check_eq("idle_grant", 256'(arb_grant), 256'(0));
    check_eq("idle_busy", 256'(arb_busy), 256'(0));
    check_eq("idle_wreq", 256'(ddr_wreq), 256'(0));
    check_eq("idle_wdata", 256'(ddr_wdata), 256'(0));
  endtask

  initial begin
    rst = 1'b1;
    exp_err = 1'b0;
    s_wreq = '0;
    s_waddr = '0;
    s_wr_len = '0;
    ddr_wdata_req = 1'b1;
    ddr_wdone = 1'b1;
    rand_data();
    #2;
    check_eq("rst_grant", 256'(arb_grant), 256'(0));
    check_eq("rst_wreq", 256'(ddr_wreq), 256'(0));
    check_eq("rst_waddr", 256'(ddr_waddr), 256'(0));
    check_eq("rst_wr_len", 256'(ddr_wr_len), 256'(0));
    check_eq("rst_busy", 256'(arb_busy), 256'(0));
    check_eq("rst_err", 256'(arb_err), 256'(0));
    check_eq("rst_s_wdata_req", 256'(s_wdata_req), 256'(0));
    check_eq("rst_s_wdone", 256'(s_wdone), 256'(0));
    check_eq("rst_wdata", 256'(ddr_wdata), 256'(0));
    apply_reset();

    // Single channel, fixed address/length
    burst(4'b0001, FirstLen, 0, 'h100);

    // All channels requesting from reset: strict rotation 0,1,2,3,...
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      burst(4'b1111, 0, 0, -1);
      check_eq("rr_order", 256'(ptr), 256'(i % CH));
    end

    // Stray data strobe in IDLE
    ddr_wdata_req = 1'b1;
    #1;
    check_eq("idle_strobe_route", 256'(s_wdata_req), 256'(0));
    exp_err = 1'b1;
    step();
    ddr_wdata_req = 1'b0;
    step();

    // Over-length burst on ch2: error on the 5th beat, burst still completes
    ptr = 1;
    apply_reset();
    ptr = CH - 1;
    burst(4'b0100, 4, 1, -1);

    // Reset in the middle of a ch1 burst
    apply_reset();
    s_wr_len[1*LW +: LW] = LW'(8);
    s_wreq = 4'b0010;
    step();
    s_wreq = '0;
    check_eq("mid_grant", 256'(arb_grant), 256'(4'b0010));
    repeat (2) begin
      ddr_wdata_req = 1'b1;
      step();
      ddr_wdata_req = 1'b0;
    end
    rst = 1'b1;
    ddr_wdata_req = 1'b1;
    ddr_wdone = 1'b1;
    #1;
    check_eq("mid_rst_grant", 256'(arb_grant), 256'(0));
    check_eq("mid_rst_s_wdone", 256'(s_wdone), 256'(0));
    check_eq("mid_rst_s_wdata_req", 256'(s_wdata_req), 256'(0));
    check_eq("mid_rst_wreq", 256'(ddr_wreq), 256'(0));
    check_eq("mid_rst_busy", 256'(arb_busy), 256'(0));
    check_eq("mid_rst_wdata", 256'(ddr_wdata), 256'(0));
    ddr_wdata_req = 1'b0;
    ddr_wdone = 1'b0;
    step();
    rst = 1'b0;
    ptr = CH - 1;
    burst(4'b0011, 0, 0, -1);
    check_eq("post_rst_winner", 256'(ptr), 256'(0));

`ifdef WR_ARB_TIMEOUT_EN
    apply_reset();
    s_wreq = 4'b0001;
    step();
    s_wreq = '0;
    check_eq("tmo_grant", 256'(arb_grant), 256'(1));
    repeat (TMO - 1) step();
    exp_err = 1'b1;
    step();
    check_eq("tmo_grant_clr", 256'(arb_grant), 256'(0));
    check_eq("tmo_wreq", 256'(ddr_wreq), 256'(0));
    check_eq("tmo_busy", 256'(arb_busy), 256'(0));
    ptr = 0;
    burst(4'b0011, 0, 0, -1);
    check_eq("tmo_next_winner", 256'(ptr), 256'(1));
`endif

    // Random request patterns
    repeat (30) burst(CH'($urandom_range(15, 1)), 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
